proc_dpath_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the X stage of the pipelined processor datapath. It is the next generation of the single-function iterative multiplier: configurable operand width, all eight RISC-V M-extension operations, and a kill input so the pipeline can abort an in-flight operation on squash. The pipeline issues operands in D with a val/rdy request and collects the result in X with a val/rdy response, exactly as it does with the multiplier today.

---
 rtl/proc_dpath_muldiv_if.sv | 24 ++
 rtl/proc_dpath_muldiv.sv | 149 ++++++++++++++
 tb/tb_proc_dpath_muldiv.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_dpath_muldiv_if.sv
// Request/response bus between the pipeline (master) and the mul/div unit (slave).
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the sender keeps its payload stable while
// valid is high and ready is low, and ready never depends on valid.
interface proc_dpath_muldiv_if #(parameter int p_nbits = 32);
  logic               req_val;
  logic               req_rdy;
  logic [2:0]         req_fn;
  logic [p_nbits-1:0] req_a;
  logic [p_nbits-1:0] req_b;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_nbits-1:0] resp_msg;

  modport master (
    output req_val, req_fn, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_fn, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/proc_dpath_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit for the X stage.
// One multiplier/quotient bit per CALC cycle over operand magnitudes; signs are
// re-applied on the final iteration. Divide-by-zero and signed overflow finish
// straight from IDLE. kill aborts whatever is in flight.
module proc_dpath_muldiv #(
  parameter int p_nbits = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 kill,
  proc_dpath_muldiv_if.slave   bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(p_nbits) + 1;
  localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [2:0]             fn;
  logic                   sign_a;
  logic                   sign_b;
  logic [p_nbits-1:0]     opb;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*p_nbits-1:0]   acc;   // mul: {partial product, multiplier}; div: low half = dividend/quotient
  logic [p_nbits:0]       rem;
  logic [CW-1:0]          cnt;

  // Request decode
  logic               is_div, a_signed, b_signed, a_neg, b_neg;
  logic               b_zero, ovf, special, req_go;
  logic [p_nbits-1:0] mag_a, mag_b, special_res;

  assign is_div   = bus.req_fn[2];
  assign a_signed = (bus.req_fn == 3'b000) || (bus.req_fn == 3'b001) || (bus.req_fn == 3'b010)
                 || (bus.req_fn == 3'b100) || (bus.req_fn == 3'b110);
  assign b_signed = (bus.req_fn == 3'b000) || (bus.req_fn == 3'b001)
                 || (bus.req_fn == 3'b100) || (bus.req_fn == 3'b110);
  assign a_neg    = a_signed && bus.req_a[p_nbits-1];
  assign b_neg    = b_signed && bus.req_b[p_nbits-1];
  assign mag_a    = a_neg ? (~bus.req_a + 1'b1) : bus.req_a;
  assign mag_b    = b_neg ? (~bus.req_b + 1'b1) : bus.req_b;
  assign b_zero   = (bus.req_b == '0);
  assign ovf      = ((bus.req_fn == 3'b100) || (bus.req_fn == 3'b110))
                 && (bus.req_a == {1'b1, {(p_nbits-1){1'b0}}}) && (&bus.req_b);
  assign special  = is_div && (b_zero || ovf);
  // fn[1] separates REM/REMU from DIV/DIVU
  assign special_res = b_zero ? (bus.req_fn[1] ? bus.req_a : '1)
                              : (bus.req_fn[1] ? '0 : bus.req_a);

  assign bus.req_rdy  = (state == IDLE) && !kill && !reset;
  assign bus.resp_val = (state == DONE) && !kill;
  assign req_go       = bus.req_val && bus.req_rdy;
  assign dbg_state    = state;

  // One shift-add / restoring-divide step
  logic [p_nbits:0]     mul_sum;
  logic [2*p_nbits-1:0] mul_nxt;
  logic [p_nbits:0]     div_shift, div_diff, rem_nxt;
  logic                 div_ge;
  logic [p_nbits-1:0]   quo_nxt;

  assign mul_sum   = {1'b0, acc[2*p_nbits-1:p_nbits]} + {1'b0, (acc[0] ? opb : {p_nbits{1'b0}})};
  assign mul_nxt   = {mul_sum, acc[p_nbits-1:1]};
  assign div_shift = {rem[p_nbits-1:0], acc[p_nbits-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign rem_nxt   = div_ge ? div_diff : div_shift;
  assign quo_nxt   = {acc[p_nbits-2:0], div_ge};

  // Signed fix-up and result select for the final iteration
  logic [2*p_nbits-1:0] prod_fin;
  logic [p_nbits-1:0]   quo_fin, rem_fin, result;

  assign prod_fin = (sign_a ^ sign_b) ? (~mul_nxt + 1'b1) : mul_nxt;
  assign quo_fin  = (sign_a ^ sign_b) ? (~quo_nxt + 1'b1) : quo_nxt;
  assign rem_fin  = sign_a ? (~rem_nxt[p_nbits-1:0] + 1'b1) : rem_nxt[p_nbits-1:0];

  // Pick the half / quotient / remainder the latched op asks for
  always_comb begin
    result = prod_fin[p_nbits-1:0];
    case (fn)
      3'b000:                 result = prod_fin[p_nbits-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fin[2*p_nbits-1:p_nbits];
      3'b100, 3'b101:         result = quo_fin;
      default:                result = rem_fin;
    endcase
  end

  // Control FSM plus iterative datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fn           <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      opb          <= '0;
      acc          <= '0;
      rem          <= '0;
      cnt          <= '0;
      bus.resp_msg <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_go) begin
            fn     <= bus.req_fn;
            sign_a <= a_neg;
            sign_b <= b_neg;
            cnt    <= '0;
            rem    <= '0;
            opb    <= is_div ? mag_b : mag_a;
            acc    <= {{p_nbits{1'b0}}, (is_div ? mag_a : mag_b)};
            if (special) begin
              bus.resp_msg <= special_res;
              state        <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (fn[2]) begin
            acc[p_nbits-1:0] <= quo_nxt;
            rem              <= rem_nxt;
          end else begin
            acc <= mul_nxt;
          end
          if (cnt == LAST) begin
            bus.resp_msg <= result;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_val && bus.resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_dpath_muldiv.sv
// Bench for proc_dpath_muldiv: a 32-bit and an 8-bit instance share stimulus,
// sel8 picks which one is exercised. Expected results come from an integer
// model of the M-extension rules.
module tb_proc_dpath_muldiv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / observation ----------------
  logic        sel8 = 1'b0;
  logic        kill = 1'b0;
  logic        req_val = 1'b0;
  logic [2:0]  req_fn = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_rdy = 1'b0;
  logic [1:0]  st32, st8;

  proc_dpath_muldiv_if #(.p_nbits(32)) bus32 ();
  proc_dpath_muldiv_if #(.p_nbits(8))  bus8 ();

  assign bus32.req_val  = req_val && !sel8;
  assign bus32.req_fn   = req_fn;
  assign bus32.req_a    = req_a;
  assign bus32.req_b    = req_b;
  assign bus32.resp_rdy = resp_rdy && !sel8;
  assign bus8.req_val   = req_val && sel8;
  assign bus8.req_fn    = req_fn;
  assign bus8.req_a     = req_a[7:0];
  assign bus8.req_b     = req_b[7:0];
  assign bus8.resp_rdy  = resp_rdy && sel8;

  proc_dpath_muldiv #(.p_nbits(32)) dut32 (
    .clk(clk), .reset(reset), .kill(kill && !sel8), .bus(bus32), .dbg_state(st32)
  );
  proc_dpath_muldiv #(.p_nbits(8)) dut8 (
    .clk(clk), .reset(reset), .kill(kill && sel8), .bus(bus8), .dbg_state(st8)
  );

  logic        obs_rdy, obs_val;
  logic [31:0] obs_msg;
  assign obs_rdy = sel8 ? bus8.req_rdy  : bus32.req_rdy;
  assign obs_val = sel8 ? bus8.resp_val : bus32.resp_val;
  assign obs_msg = sel8 ? {24'd0, bus8.resp_msg} : bus32.resp_msg;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input int n, input logic [2:0] fn,
                                        input logic [31:0] a, input logic [31:0] b,
                                        output bit special);
    longint m, av, bv, sa, sb, q, r;
    logic [63:0] p;
    bit a_s, b_s;
    m   = (longint'(1) << n) - 1;
    av  = longint'({32'd0, a}) & m;
    bv  = longint'({32'd0, b}) & m;
    a_s = fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    b_s = fn inside {3'd0, 3'd1, 3'd4, 3'd6};
    sa  = (a_s && ((av >> (n - 1)) & 1) == 1) ? av - (longint'(1) << n) : av;
    sb  = (b_s && ((bv >> (n - 1)) & 1) == 1) ? bv - (longint'(1) << n) : bv;
    special = 1'b0;
    if (!fn[2]) begin
      p = 64'(sa * sb);
      if (fn == 3'd0) return 32'(p & 64'(m));
      return 32'((p >> n) & 64'(m));
    end
    if (bv == 0) begin
      special = 1'b1;
      return fn[1] ? 32'(av) : 32'(m);
    end
    if (a_s && sa == -(longint'(1) << (n - 1)) && sb == -1) begin
      special = 1'b1;
      return fn[1] ? 32'd0 : 32'(av);
    end
    q = sa / sb;
    r = sa % sb;
    return fn[1] ? 32'(r & m) : 32'(q & m);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output bit ok);
    req_val = 1'b1; req_fn = fn; req_a = a; req_b = b;
    #1;
    for (int i = 0; i < 20 && !obs_rdy; i++) begin
      @(negedge clk); #1;
    end
    check("req_rdy_before_accept", {31'd0, obs_rdy}, 32'd1);
    ok = obs_rdy;
    if (ok) @(negedge clk);
    req_val = 1'b0;
  endtask

  // Counts edges after accept until resp_val is seen, bounded.
  task automatic wait_resp(input int n, output int k);
    k = 0;
    #1;
    while (!obs_val && k < 2 * n + 10) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int n, k;
    bit ok, spec;
    logic [31:0] e;
    n = sel8 ? 8 : 32;
    exp_q.push_back(model(n, fn, a, b, spec));
    send_req(fn, a, b, ok);
    if (!ok) begin void'(exp_q.pop_front()); return; end
    wait_resp(n, k);
    check({tag, "_resp_val"}, {31'd0, obs_val}, 32'd1);
    if (!obs_val) begin void'(exp_q.pop_front()); return; end
    check({tag, "_latency"}, k, spec ? 0 : n);
    check({tag, "_req_rdy_busy"}, {31'd0, obs_rdy}, 32'd0);
    e = exp_q.pop_front();
    check({tag, "_result"}, obs_msg, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check({tag, "_hold_val"}, {31'd0, obs_val}, 32'd1);
      check({tag, "_hold_msg"}, obs_msg, e);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    #1;
    check({tag, "_val_after_xfer"}, {31'd0, obs_val}, 32'd0);
    check({tag, "_rdy_after_xfer"}, {31'd0, obs_rdy}, 32'd1);
    check({tag, "_msg_kept"}, obs_msg, e);
  endtask

  task automatic random_ops(input int count);
    logic [31:0] a, b, mn, m1;
    logic [2:0] fn;
    int kind;
    mn = sel8 ? 32'h80 : 32'h8000_0000;
    m1 = sel8 ? 32'hFF : 32'hFFFF_FFFF;
    for (int i = 0; i < count; i++) begin
      fn   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      if (kind == 0) b = 32'd0;
      if (kind == 1) begin a = mn; b = m1; end
      if (kind == 2) b = 32'($urandom_range(1, 9));
      run_op($sformatf("rnd%0d_fn%0d", i, fn), fn, a, b, $urandom_range(0, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit ok;
    repeat (3) @(negedge clk);
    #1;
    check("reset_req_rdy", {31'd0, obs_rdy}, 32'd0);
    check("reset_resp_val", {31'd0, obs_val}, 32'd0);
    check("reset_resp_msg", obs_msg, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_req_rdy", {31'd0, obs_rdy}, 32'd1);
    @(negedge clk);

    // 32-bit directed cases
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5);
    run_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
    run_op("div_5_0", 3'd4, 32'd5, 32'd0, 2);
    run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // kill during CALC
    send_req(3'd4, 32'd1000, 32'd3, ok);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    #1;
    check("kill_calc_resp_val", {31'd0, obs_val}, 32'd0);
    check("kill_calc_req_rdy", {31'd0, obs_rdy}, 32'd0);
    @(negedge clk);
    #1;
    check("kill_held_req_rdy", {31'd0, obs_rdy}, 32'd0);
    kill = 1'b0;
    #1;
    check("after_kill_req_rdy", {31'd0, obs_rdy}, 32'd1);
    check("after_kill_resp_val", {31'd0, obs_val}, 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check("killed_no_resp", {31'd0, obs_val}, 32'd0);
    run_op("mul_3_4_after_kill", 3'd0, 32'd3, 32'd4, 0);

    // kill with resp_rdy in DONE
    send_req(3'd0, 32'd5, 32'd6, ok);
    wait_resp(32, k);
    check("kill_done_resp_seen", {31'd0, obs_val}, 32'd1);
    check("kill_done_result", obs_msg, 32'd30);
    kill = 1'b1;
    resp_rdy = 1'b1;
    #1;
    check("kill_done_resp_val", {31'd0, obs_val}, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    resp_rdy = 1'b0;
    #1;
    check("kill_done_no_xfer_val", {31'd0, obs_val}, 32'd0);
    check("kill_done_req_rdy", {31'd0, obs_rdy}, 32'd1);

    // reset mid-CALC
    send_req(3'd5, 32'd100, 32'd7, ok);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_calc_req_rdy", {31'd0, obs_rdy}, 32'd0);
    check("rst_calc_resp_val", {31'd0, obs_val}, 32'd0);
    check("rst_calc_resp_msg", obs_msg, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_req_rdy", {31'd0, obs_rdy}, 32'd1);
    repeat (40) @(negedge clk);
    #1;
    check("rst_no_resp", {31'd0, obs_val}, 32'd0);

    random_ops(25);

    // 8-bit instance
    sel8 = 1'b1;
    @(negedge clk);
    run_op("w8_mul_7_m3", 3'd0, 32'd7, 32'hFD, 5);
    run_op("w8_mul_16_16", 3'd0, 32'h10, 32'h10, 0);
    run_op("w8_div_m7_2", 3'd4, 32'hF9, 32'd2, 0);
    run_op("w8_rem_m7_2", 3'd6, 32'hF9, 32'd2, 0);
    run_op("w8_divu_100_7", 3'd5, 32'd100, 32'd7, 0);
    run_op("w8_remu_100_7", 3'd7, 32'd100, 32'd7, 0);
    run_op("w8_div_ovf", 3'd4, 32'h80, 32'hFF, 0);
    run_op("w8_mulhu_ff", 3'd3, 32'hFF, 32'hFF, 0);
    random_ops(25);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Overall guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
